rr_grant_arbiter: RTL and testbench

- Registered, parameterised request arbiter for the cache datapath.
- Selects one of `WIDTH` requesters per grant, using either fixed MSB-first priority or rotating round-robin priority.
- Holds each grant under a valid/ready handshake until the consumer accepts it.
- Sits in front of shared cache resources (MSHR allocation, refill port, tag-write port) in place of bare combinational encoding.

---
 rtl/arb_pkg.sv | 19 +
 rtl/priority_encoder_parameterized.sv | 22 ++
 rtl/rr_grant_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter.
package arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // $clog2 collapses to 0 for a single requester; the index port stays 1 bit wide.
   function automatic int arb_idx_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/priority_encoder_parameterized.sv
// MSB-first priority encoder: idx is the highest set bit of vec, any flags a non-zero vec.
module priority_encoder_parameterized #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered request arbiter with valid/ready grant hold, fixed or round-robin priority.
// Optional grant locking for multi-beat bursts is enabled by defining ARB_LOCK_EN.
//
// state    | meaning
// ST_IDLE  | no grant presented, arbitrate every cycle
// ST_GRANT | grant presented and held until gnt_ready
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int        WIDTH = 8,
   parameter arb_mode_e MODE  = ARB_RR,
   localparam int       IDX_W = arb_idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   input  logic             gnt_ready,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [WIDTH-1:0] gnt_onehot
);

   localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W:0]   WIDTH_X = (IDX_W + 1)'(WIDTH);

   arb_state_e       state;
   logic [IDX_W-1:0] ptr;

   logic             accept;
   logic             load;
   logic             lock_hit;
   logic [IDX_W-1:0] ptr_adv;
   logic [IDX_W-1:0] ptr_arb;
   logic [WIDTH-1:0] req_eff;
   logic [IDX_W:0]   rot_sh;
   logic [2*WIDTH-1:0] req_dbl;
   logic [WIDTH-1:0] rot;
   logic [IDX_W-1:0] enc;
   logic             enc_any;
   logic [IDX_W:0]   win_sum;
   logic [IDX_W:0]   win_mod;
   logic [IDX_W-1:0] gnt_next;
   logic [WIDTH-1:0] onehot_next;

   assign accept = gnt_valid & gnt_ready;
   assign load   = (state == ST_IDLE) | accept;

`ifdef ARB_LOCK_EN
   assign lock_hit = accept & lock & (|(req & gnt_onehot));
`else
   assign lock_hit = 1'b0;
`endif

   assign ptr_adv = (gnt_idx == '0) ? LAST : gnt_idx - 1'b1;

   // The arbitration taken at an accepting edge already sees the advanced pointer.
   assign ptr_arb = ((MODE == ARB_RR) && accept && !lock_hit) ? ptr_adv : ptr;

   assign req_eff = req & ~(accept ? gnt_onehot : '0);

   // rot[j] = req_eff[(j+ptr+1) mod WIDTH]; ptr+1 never exceeds WIDTH, so a
   // right shift of the doubled vector performs the wrap.
   assign rot_sh  = {1'b0, ptr_arb} + 1'b1;
   assign req_dbl = {req_eff, req_eff};
   assign rot     = WIDTH'(req_dbl >> rot_sh);

   priority_encoder_parameterized #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_enc (
      .vec (rot),
      .idx (enc),
      .any (enc_any)
   );

   // Un-rotate with an explicit modulo so non-power-of-two widths wrap correctly.
   assign win_sum  = {1'b0, enc} + {1'b0, ptr_arb} + 1'b1;
   assign win_mod  = (win_sum >= WIDTH_X) ? (win_sum - WIDTH_X) : win_sum;
   assign gnt_next = win_mod[IDX_W-1:0];

   always_comb begin
      onehot_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         onehot_next[i] = (gnt_next == IDX_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         ptr        <= LAST;
      end else begin
         if ((MODE == ARB_RR) && accept && !lock_hit) begin
            ptr <= ptr_adv;
         end
         if (load) begin
            if (lock_hit) begin
               state     <= ST_GRANT;
               gnt_valid <= 1'b1;
            end else if (enc_any) begin
               state      <= ST_GRANT;
               gnt_valid  <= 1'b1;
               gnt_idx    <= gnt_next;
               gnt_onehot <= onehot_next;
            end else begin
               state      <= ST_IDLE;
               gnt_valid  <= 1'b0;
               gnt_idx    <= '0;
               gnt_onehot <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic against a priority-scan model.
module tb_rr_grant_arbiter;
   import arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;
   logic       gnt_ready = 1'b0;
   logic       lock = 1'b0;

   logic       gv_rr, gv_fx, gv_w5;
   logic [2:0] gi_rr, gi_fx, gi_w5;
   logic [7:0] oh_rr, oh_fx;
   logic [4:0] oh_w5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rr_grant_arbiter #(.WIDTH(8), .MODE(ARB_RR)) u_rr (
      .clk(clk), .rst(rst), .req(req), .gnt_ready(gnt_ready),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt_valid(gv_rr), .gnt_idx(gi_rr), .gnt_onehot(oh_rr)
   );

   rr_grant_arbiter #(.WIDTH(8), .MODE(ARB_FIXED)) u_fx (
      .clk(clk), .rst(rst), .req(req), .gnt_ready(gnt_ready),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt_valid(gv_fx), .gnt_idx(gi_fx), .gnt_onehot(oh_fx)
   );

   rr_grant_arbiter #(.WIDTH(5), .MODE(ARB_RR)) u_w5 (
      .clk(clk), .rst(rst), .req(req[4:0]), .gnt_ready(gnt_ready),
`ifdef ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt_valid(gv_w5), .gnt_idx(gi_w5), .gnt_onehot(oh_w5)
   );

   typedef struct {
      bit valid;
      int idx;
      int ptr;
   } mdl_t;

   mdl_t m_rr, m_fx, m_w5;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mdl_t mdl_reset(input int w);
      mdl_t m;
      m.valid = 1'b0;
      m.idx   = 0;
      m.ptr   = w - 1;
      return m;
   endfunction

   // Scan priorities ptr, ptr-1, ... wrapping, and pick the first live request.
   function automatic mdl_t mdl_step(input mdl_t m, input int unsigned rq, input bit rdy,
                                     input bit lk, input int w, input bit rr);
      mdl_t n = m;
      bit acc = m.valid && rdy;
      int unsigned eff;
      if (m.valid && !acc) return n;
      if (acc && lk && ((rq >> m.idx) & 1) != 0) return n;
      eff = rq & ((1 << w) - 1);
      if (acc) begin
         eff &= ~(32'd1 << m.idx);
         if (rr) n.ptr = (m.idx == 0) ? w - 1 : m.idx - 1;
      end
      n.valid = 1'b0;
      n.idx   = 0;
      for (int k = 0; k < w; k++) begin
         int c = (n.ptr - k + w) % w;
         if (((eff >> c) & 1) != 0) begin
            n.valid = 1'b1;
            n.idx   = c;
            break;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] mdl_oh(input mdl_t m);
      return m.valid ? (32'd1 << m.idx) : 32'd0;
   endfunction

   task automatic cmp_all();
      chk("rr_valid", 32'(gv_rr), 32'(m_rr.valid));
      chk("rr_onehot", 32'(oh_rr), mdl_oh(m_rr));
      if (m_rr.valid) chk("rr_idx", 32'(gi_rr), 32'(m_rr.idx));
      chk("fx_valid", 32'(gv_fx), 32'(m_fx.valid));
      chk("fx_onehot", 32'(oh_fx), mdl_oh(m_fx));
      if (m_fx.valid) chk("fx_idx", 32'(gi_fx), 32'(m_fx.idx));
      chk("w5_valid", 32'(gv_w5), 32'(m_w5.valid));
      chk("w5_onehot", 32'(oh_w5), mdl_oh(m_w5));
      if (m_w5.valid) chk("w5_idx", 32'(gi_w5), 32'(m_w5.idx));
   endtask

   // Called #1 after a rising edge; applies inputs, steps models, checks after the next edge.
   task automatic tick(input logic [7:0] r, input logic rdy, input logic lk);
      bit lk_eff;
`ifdef ARB_LOCK_EN
      lk_eff = lk;
`else
      lk_eff = 1'b0;
`endif
      req = r;
      gnt_ready = rdy;
      lock = lk;
      @(posedge clk);
      m_rr = mdl_step(m_rr, 32'(r), rdy, lk_eff, 8, 1'b1);
      m_fx = mdl_step(m_fx, 32'(r), rdy, lk_eff, 8, 1'b0);
      m_w5 = mdl_step(m_w5, 32'(r), rdy, lk_eff, 5, 1'b1);
      #1;
      cmp_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'({gv_rr, gv_fx, gv_w5}), 32'd0);
      chk("rst_onehot", 32'({oh_rr, oh_fx, oh_w5}), 32'd0);
      chk("rst_idx", 32'({gi_rr, gi_fx, gi_w5}), 32'd0);
      m_rr = mdl_reset(8);
      m_fx = mdl_reset(8);
      m_w5 = mdl_reset(5);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      logic       rdy, lk;

      m_rr = mdl_reset(8);
      m_fx = mdl_reset(8);
      m_w5 = mdl_reset(5);
      @(posedge clk);
      #1;
      do_reset();

      // reset while a grant is outstanding
      tick(8'hFF, 1'b0, 1'b0);
      tick(8'hFF, 1'b0, 1'b0);
      chk("pre_rst_grant", 32'(gi_rr), 32'd7);
      do_reset();
      chk("rst_ptr", 32'(u_rr.ptr), 32'd7);
      tick(8'h01, 1'b1, 1'b0);
      chk("post_rst_first", 32'({gv_rr, gi_rr}), 32'({1'b1, 3'd0}));

      // round-robin alternating pair
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick(8'h81, 1'b1, 1'b0);
         chk("rr_pair", 32'({gv_rr, gi_rr}), (i % 2 == 0) ? 32'h0F : 32'h08);
         chk("fx_pair", 32'({gv_fx, gi_fx}), (i % 2 == 0) ? 32'h0F : 32'h08);
      end

      // fixed priority with two high requesters
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick(8'hC0, 1'b1, 1'b0);
         chk("fx_c0", 32'(gi_fx), (i % 2 == 0) ? 32'd7 : 32'd6);
      end

      // backpressure holds the grant
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick(8'h24, 1'b0, 1'b0);
         chk("bp_hold", 32'({gv_rr, gi_rr}), 32'h0D);
      end
      tick(8'h24, 1'b1, 1'b0);
      chk("bp_next", 32'(gi_rr), 32'd2);

      // non-power-of-two width
      do_reset();
      tick(8'h11, 1'b1, 1'b0);
      chk("w5_seq0", 32'(gi_w5), 32'd4);
      tick(8'h11, 1'b1, 1'b0);
      chk("w5_seq1", 32'(gi_w5), 32'd0);
      chk("w5_ptr3", 32'(u_w5.ptr), 32'd3);
      tick(8'h11, 1'b1, 1'b0);
      chk("w5_seq2", 32'(gi_w5), 32'd4);
      chk("w5_ptr4", 32'(u_w5.ptr), 32'd4);

`ifdef ARB_LOCK_EN
      do_reset();
      tick(8'h0C, 1'b0, 1'b0);
      chk("lock_first", 32'(gi_rr), 32'd3);
      tick(8'h0C, 1'b1, 1'b1);
      chk("lock_hold", 32'(gi_rr), 32'd3);
      tick(8'h0C, 1'b1, 1'b0);
      chk("lock_release", 32'(gi_rr), 32'd2);
`endif

      // random traffic; outstanding grants keep their request high
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
         if (m_rr.valid) r = r | 8'(32'd1 << m_rr.idx);
         if (m_fx.valid) r = r | 8'(32'd1 << m_fx.idx);
         if (m_w5.valid) r = r | 8'(32'd1 << m_w5.idx);
         rdy = ($urandom_range(0, 3) != 0);
         lk  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         tick(r, rdy, lk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
